// File: rtl/stage2_fsm_stream_if.sv
`default_nettype none
// =============================================================================
// stage2_fsm_stream_if : valid/ready stream bundle; tag = key (in) / state (out)
// Rev 1.0
// =============================================================================
interface stage2_fsm_stream_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [1:0]        tag;

  modport master (output valid, output data, output tag, input ready);
  modport slave  (input valid, input data, input tag, output ready);
endinterface
`default_nettype wire

// File: rtl/stage2_fsm_stream.sv
`default_nettype none
// =============================================================================
// stage2_fsm_stream : keyed 4-state transform with output reg + skid buffer.
// Optional trace: define STAGE2_FSM_STREAM_TRACE_EN.   Rev 1.0
// =============================================================================
module stage2_fsm_stream #(
  parameter int DATA_W    = 16,
  parameter int SEXT_W    = 4,
  parameter int ROUND_LEN = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  stage2_fsm_stream_if.slave     in_if,
  stage2_fsm_stream_if.master    out_if
);

  localparam int                CNT_W    = $clog2(ROUND_LEN);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ROUND_LEN - 1);
  localparam logic [DATA_W-1:0] MASK_10  = {(DATA_W/2){2'b10}};
  localparam logic [DATA_W-1:0] MASK_01  = {(DATA_W/2){2'b01}};

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  round_cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [1:0]        out_state_q;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [1:0]        skid_state;

  logic              accept;
  logic              transfer;
  logic              load_skid;
  logic              skid_next;
  logic [DATA_W-1:0] xform;

  assign accept   = in_if.valid && in_ready_q;
  assign transfer = out_valid_q && out_if.ready;

  // A new beat lands in the skid whenever the output register stays occupied.
  assign load_skid = transfer ? skid_valid : out_valid_q;
  assign skid_next = (accept && load_skid) || (skid_valid && !transfer);

  always_comb begin
    xform = '0;
    case (state)
      S0:      xform = {{(DATA_W-1){1'b0}}, ^in_if.data};
      S1:      xform = in_if.data & MASK_10;
      S2:      xform = in_if.data | MASK_01;
      default: xform = {{SEXT_W{in_if.data[DATA_W-1]}}, in_if.data[DATA_W-SEXT_W-1:0]};
    endcase
  end

  always_comb begin
    next_state = S0;
    if (round_cnt != LAST_CNT) begin
      case (state)
        S0:      next_state = state_t'(in_if.tag ^ 2'd1);
        S1:      next_state = state_t'(in_if.tag ^ 2'd2);
        S2:      next_state = state_t'(in_if.tag ^ 2'd3);
        default: next_state = state_t'(in_if.tag);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S0;
      round_cnt   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_state_q <= 2'd0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_state  <= 2'd0;
    end else begin
      if (accept) begin
        state     <= next_state;
        round_cnt <= (round_cnt == LAST_CNT) ? '0 : round_cnt + 1'b1;
      end
      if (accept && load_skid) begin
        skid_data  <= xform;
        skid_state <= state;
      end
      skid_valid <= skid_next;
      in_ready_q <= !skid_next;

      if (transfer && skid_valid) begin
        out_data_q  <= skid_data;
        out_state_q <= skid_state;
        out_valid_q <= 1'b1;
      end else if (accept && (transfer || !out_valid_q)) begin
        out_data_q  <= xform;
        out_state_q <= state;
        out_valid_q <= 1'b1;
      end else if (transfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef STAGE2_FSM_STREAM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && accept)
      $display("%0t stage2 %0d->%0d data=%h round=%0d",
               $time, state, next_state, in_if.data, round_cnt);
  end
`endif

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign out_if.tag   = out_state_q;

endmodule
`default_nettype wire
